// File: rtl/cp0_unit.sv
// cp0_unit: CP0 responder holding Status/Cause/EPC (+ Count/Compare timer under CP0_TIMER_EN); ports: clk, rst, ena, mfc0, mtc0, eret, exception, cause_in, addr, wdata, npc -> rdata, exc_addr, status, timer_int
module cp0_unit #(
  parameter logic [31:0] STATUS_RST = 32'h0000_0000,
  parameter int          SHIFT_AMT  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic        eret,
  input  logic        exception,
  input  logic [4:0]  cause_in,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] npc,
  output logic [31:0] rdata,
  output logic [31:0] exc_addr,
  output logic [31:0] status,
  output logic        timer_int
);
  localparam logic [4:0] A_COUNT = 5'd9, A_COMPARE = 5'd11, A_STATUS = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;
  logic [31:0] status_q, epc_q, status_d, epc_d, cause_v, count_v, compare_v, sel;
  logic [4:0]  exc_code_q, exc_code_d;
  logic        ip7;
  logic        wr_status, wr_cause, wr_epc;
  assign wr_status = mtc0 && addr == A_STATUS;
  assign wr_cause  = mtc0 && addr == A_CAUSE;
  assign wr_epc    = mtc0 && addr == A_EPC;
  always_comb begin
    status_d   = exception ? status_q << SHIFT_AMT : eret ? status_q >> SHIFT_AMT : wr_status ? wdata : status_q;
    epc_d      = exception ? npc : wr_epc ? wdata : epc_q;
    exc_code_d = exception ? cause_in : wr_cause ? wdata[6:2] : exc_code_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      exc_code_q <= '0;
    end else if (ena) begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      exc_code_q <= exc_code_d;
    end
  end
`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        ip7_q;
  // IP7: Compare write clears, a match sets and holds, otherwise a Cause write may load it
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ip7_q     <= 1'b0;
    end else if (ena) begin
      count_q   <= (mtc0 && addr == A_COUNT) ? wdata : count_q + 32'd1;
      compare_q <= (mtc0 && addr == A_COMPARE) ? wdata : compare_q;
      ip7_q     <= (mtc0 && addr == A_COMPARE) ? 1'b0 :
                   (compare_q != '0 && count_q == compare_q) ? 1'b1 :
                   wr_cause ? wdata[15] : ip7_q;
    end
  end
  assign count_v   = count_q;
  assign compare_v = compare_q;
  assign ip7       = ip7_q;
  assign timer_int = ip7_q & status_q[15] & status_q[0];
`else
  assign count_v   = '0;
  assign compare_v = '0;
  assign ip7       = 1'b0;
  assign timer_int = 1'b0;
`endif
  assign cause_v = {16'b0, ip7, 8'b0, exc_code_q, 2'b0};
  always_comb begin
    sel   = addr == A_STATUS ? status_q : addr == A_CAUSE ? cause_v : addr == A_EPC ? epc_q :
            addr == A_COUNT ? count_v : addr == A_COMPARE ? compare_v : '0;
    rdata = mfc0 ? sel : '0;
  end
  assign exc_addr = epc_q;
  assign status   = status_q;
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: scoreboard bench for cp0_unit against an array-based register model
module tb_cp0_unit;
  logic clk = 1'b0, rst, ena, mfc0, mtc0, eret, exception, timer_int;
  logic [4:0] cause_in, addr;
  logic [31:0] wdata, npc, rdata, exc_addr, status;
  always #5 clk = ~clk;
  cp0_unit dut (.clk(clk), .rst(rst), .ena(ena), .mfc0(mfc0), .mtc0(mtc0), .eret(eret),
                .exception(exception), .cause_in(cause_in), .addr(addr), .wdata(wdata), .npc(npc),
                .rdata(rdata), .exc_addr(exc_addr), .status(status), .timer_int(timer_int));
`ifdef CP0_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif
  localparam logic [31:0] CMASK = TMR ? 32'h0000_807C : 32'h0000_007C;
  typedef struct {bit chk; logic [31:0] rd, ea, st; logic ti;} exp_t;
  exp_t q[$];
  logic [31:0] m [0:31];
  int errs = 0, checks = 0;
  function automatic bit impl(input logic [4:0] a);
    return a == 5'd12 || a == 5'd13 || a == 5'd14 || (TMR && (a == 5'd9 || a == 5'd11));
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        cmp("rdata", rdata, e.rd);
        cmp("exc_addr", exc_addr, e.ea);
        cmp("status", status, e.st);
        cmp("timer_int", {31'b0, timer_int}, {31'b0, e.ti});
      end
    end
  end
  task automatic cyc(input logic r, en, rd, wr, er, ex, input logic [4:0] ci, a, input logic [31:0] wd, pc);
    exp_t e;
    logic [31:0] n [0:31];
    @(posedge clk);
    #1;
    rst = r; ena = en; mfc0 = rd; mtc0 = wr; eret = er; exception = ex;
    cause_in = ci; addr = a; wdata = wd; npc = pc;
    e.chk = !r;
    e.rd  = rd ? m[a] : 32'h0;
    e.ea  = m[14];
    e.st  = m[12];
    e.ti  = TMR & m[13][15] & m[12][15] & m[12][0];
    q.push_back(e);
    n = m;
    if (r) begin
      foreach (n[i]) n[i] = 32'h0;
      n[12] = 32'h0;
    end else if (en) begin
      if (TMR) n[9] = m[9] + 32'd1;
      if (wr && impl(a)) n[a] = (a == 5'd13) ? wd & CMASK : wd;
      if (TMR && m[11] != 0 && m[9] == m[11]) n[13][15] = 1'b1;
      if (TMR && wr && a == 5'd11) n[13][15] = 1'b0;
      if (ex) begin
        n[14] = pc;
        n[13][6:2] = ci;
        n[12] = m[12] << 5;
      end else if (er) n[12] = m[12] >> 5;
    end
    m = n;
  endtask
  task automatic rd_(input logic [4:0] a);
    cyc(0, 1, 1, 0, 0, 0, 0, a, 0, 0);
  endtask
  task automatic wr_(input logic [4:0] a, input logic [31:0] d);
    cyc(0, 1, 0, 1, 0, 0, 0, a, d, 0);
  endtask
  initial begin
    foreach (m[i]) m[i] = 32'h0;
    rst = 1; ena = 0; mfc0 = 0; mtc0 = 0; eret = 0; exception = 0;
    cause_in = 0; addr = 0; wdata = 0; npc = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd_(12); rd_(13); rd_(14);
    wr_(12, 32'h0000_001F); rd_(12);
    wr_(7, 32'hDEAD_BEEF); rd_(7);
    cyc(0, 1, 0, 0, 0, 1, 5'b01000, 0, 0, 32'h0040_0010);
    rd_(14); rd_(13); rd_(12);
    cyc(0, 1, 1, 0, 1, 0, 0, 12, 0, 0);
    rd_(12);
    cyc(0, 1, 0, 1, 0, 1, 5'd4, 14, 32'h1234_5678, 32'h0040_0100);
    rd_(14);
    cyc(0, 0, 0, 0, 0, 1, 5'd3, 0, 0, 32'hFFFF_0000);
    rd_(14); rd_(13); rd_(12);
    wr_(12, 32'hA);
    cyc(0, 1, 1, 1, 0, 0, 0, 12, 32'hB, 0);
    rd_(12);
    wr_(12, 32'hFFFF_FFFF);
    repeat (7) cyc(0, 1, 0, 0, 0, 1, 5'd9, 0, 0, 32'h0000_0100);
    rd_(12);
    wr_(13, 32'hFFFF_FFFF); rd_(13);
    if (TMR) begin
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      wr_(12, 32'h0000_8001);
      wr_(11, 32'd20);
      repeat (24) rd_(13);
      wr_(11, 32'd0); rd_(13);
      wr_(9, 32'hFFFF_FFFF); rd_(9); rd_(9);
    end
    for (int k = 0; k < 2000; k++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(9, 14));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
          5'($urandom), a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom, $urandom);
    end
    cyc(0, 1, 1, 0, 0, 0, 0, 12, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
